// File: rtl/reg_fifo.sv
// Synchronous FIFO with a registered read port and a one-cycle valid pulse.
// Define REG_FIFO_ERR_EN to add the sticky ovf_o/udf_o flags and the clr_err_i input.
module reg_fifo #(
  parameter int unsigned DATA_W              = 21,
  parameter int unsigned DEPTH_LOG2          = 3,
  parameter logic [DATA_W-1:0] RST_VAL       = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  wr_e_i,
  input  logic [DATA_W-1:0]     wr_d_i,
  input  logic                  rd_e_i,
  output logic [DATA_W-1:0]     rd_d_o,
  output logic                  rd_v_o,
  output logic                  full_o,
  output logic                  empty_o,
`ifdef REG_FIFO_ERR_EN
  output logic                  ovf_o,
  output logic                  udf_o,
  input  logic                  clr_err_i,
`endif
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LevelFull = (DEPTH_LOG2 + 1)'(Depth);

  logic [DATA_W-1:0]     mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [DATA_W-1:0]     rd_d_q, rd_d_d;
  logic                  rd_v_q, rd_v_d;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  assign full  = (level_q == LevelFull);
  assign empty = (level_q == '0);

  // A write into a full FIFO is allowed only when a read frees a slot in the same cycle.
  assign rd_acc = en_i & rd_e_i & ~empty;
  assign wr_acc = en_i & wr_e_i & (~full | rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rd_d_d   = rd_d_q;
    rd_v_d   = rd_v_q;
    if (en_i) begin
      rd_v_d = rd_acc;
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        rd_d_d   = mem_q[rd_ptr_q];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rd_d_q   <= RST_VAL;
      rd_v_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rd_d_q   <= rd_d_d;
      rd_v_q   <= rd_v_d;
    end
  end

  // Storage is deliberately not reset; a write in the reset cycle is discarded.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_d_i;
    end
  end

`ifdef REG_FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic ovf_set, udf_set;

  assign ovf_set = en_i & wr_e_i & full & ~rd_acc;
  assign udf_set = en_i & rd_e_i & empty;

  // Set takes priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (en_i) begin
      ovf_d = ovf_set | (ovf_q & ~clr_err_i);
      udf_d = udf_set | (udf_q & ~clr_err_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

  assign rd_d_o  = rd_d_q;
  assign rd_v_o  = rd_v_q;
  assign full_o  = full;
  assign empty_o = empty;
  assign level_o = level_q;

endmodule
